// File: rtl/pov_spi_loader_if.sv
// SPI bus between the external host and pov_spi_loader (mode 0).
// The host drives clock, select and data; the loader returns readback data on o_miso.
interface pov_spi_loader_if;
    logic i_sclk;
    logic i_ss_n;
    logic i_mosi;
    logic o_miso;

    modport master (output i_sclk, output i_ss_n, output i_mosi, input o_miso);
    modport slave  (input i_sclk, input i_ss_n, input i_mosi, output o_miso);
endinterface

// File: rtl/pov_spi_loader.sv
// Addressed partial-update SPI loader: rx buffer -> ready buffer (frame end) -> live words (frame sync).
// Optional readback of the live word being overwritten: define POV_SPI_READBACK_EN.
module pov_spi_loader #(
    parameter int WORD_W    = 24,
    parameter int NUM_WORDS = 6,
    parameter int HDR_W     = 8,
    parameter logic [NUM_WORDS*WORD_W-1:0] RESET_VALUE =
        {24'h001800, 24'h001800, 24'h000000, 24'h001000, 24'hFFF800, 24'h000000}
) (
    input  logic                        clk,
    input  logic                        reset_n,
    pov_spi_loader_if.slave             spi,
    input  logic                        load_if_ready,
    output logic [NUM_WORDS*WORD_W-1:0] o_words,
    output logic                        o_pending,
    output logic                        o_frame_err
);
    localparam int CNT_W = $clog2(HDR_W + WORD_W + 1);
    localparam int SR_W  = (HDR_W > WORD_W) ? HDR_W : WORD_W;
    localparam logic [HDR_W-1:0] NUM_IDX = HDR_W'(NUM_WORDS);

    typedef enum logic [1:0] {ST_UNARMED, ST_HEADER, ST_PAYLOAD, ST_REJECT} state_t;

    state_t state, state_nxt;

    logic [2:0]        sclk_sync, ss_sync;
    logic [1:0]        mosi_sync;
    logic [1:0]        warm;
    logic              sclk_rise, ss_rise, bit_take, mosi_bit;
    logic              in_header, in_payload, frame_end, reject_end, hdr_done, word_done, word_write, merge, commit;
    logic [SR_W-2:0]   sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [HDR_W-1:0]  idx, hdr_val;
    logic [WORD_W-1:0] word_val;
    logic [WORD_W-1:0] rx    [NUM_WORDS];
    logic [WORD_W-1:0] ready [NUM_WORDS];
    logic [NUM_WORDS-1:0] rx_mask, ready_mask;

    // /SS flops reset high, so they hold a fake "high" until the pin has propagated; warm gates arming until then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            warm      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi.i_sclk};
            ss_sync   <= {ss_sync[1:0], spi.i_ss_n};
            mosi_sync <= {mosi_sync[0], spi.i_mosi};
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign bit_take  = sclk_rise & ~ss_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign hdr_val   = {sr[HDR_W-2:0], mosi_bit};
    assign word_val  = {sr[WORD_W-2:0], mosi_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_UNARMED;
        else          state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_UNARMED: if (warm == 2'd3 && ss_sync[1]) state_nxt = ST_HEADER;
            ST_HEADER:  if (hdr_done) state_nxt = (hdr_val < NUM_IDX) ? ST_PAYLOAD : ST_REJECT;
            ST_PAYLOAD: if (ss_rise) state_nxt = ST_HEADER;
            ST_REJECT:  if (ss_rise) state_nxt = ST_HEADER;
            default:    state_nxt = ST_UNARMED;
        endcase
    end

    always_comb begin
        in_header  = (state == ST_HEADER);
        in_payload = (state == ST_PAYLOAD);
        frame_end  = (state != ST_UNARMED) && ss_rise;
        reject_end = (state == ST_REJECT) && ss_rise;
        hdr_done   = in_header && bit_take && (bit_cnt == CNT_W'(HDR_W - 1));
        word_done  = in_payload && bit_take && (bit_cnt == CNT_W'(WORD_W - 1));
        word_write = word_done && (idx < NUM_IDX);
        merge      = frame_end && (rx_mask != '0);
        commit     = load_if_ready && o_pending;
    end

    assign o_pending = (ready_mask != '0);

    // NOTE: the word buffers are reset along with the control state, so no X can ever be merged or committed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr          <= '0;
            bit_cnt     <= '0;
            idx         <= '0;
            rx_mask     <= '0;
            ready_mask  <= '0;
            o_frame_err <= 1'b0;
            o_words     <= RESET_VALUE;
            for (int i = 0; i < NUM_WORDS; i++) begin
                rx[i]    <= '0;
                ready[i] <= '0;
            end
        end else begin
            o_frame_err <= reject_end;

            if ((in_header || in_payload) && bit_take) sr <= {sr[SR_W-3:0], mosi_bit};

            if (frame_end || hdr_done || word_done)        bit_cnt <= '0;
            else if ((in_header || in_payload) && bit_take) bit_cnt <= bit_cnt + CNT_W'(1);

            if (hdr_done)        idx <= hdr_val;
            else if (word_write) idx <= idx + HDR_W'(1);

            for (int i = 0; i < NUM_WORDS; i++) begin
                if (word_write && idx == HDR_W'(i)) rx[i] <= word_val;
                if (merge && rx_mask[i])            ready[i] <= rx[i];
                // NOTE: non-blocking reads of ready/ready_mask give the commit the pre-merge contents on a shared edge.
                if (commit && ready_mask[i])        o_words[(NUM_WORDS-1-i)*WORD_W +: WORD_W] <= ready[i];
            end

            if (frame_end) rx_mask <= '0;
            else if (word_write) begin
                for (int i = 0; i < NUM_WORDS; i++)
                    if (idx == HDR_W'(i)) rx_mask[i] <= 1'b1;
            end

            ready_mask <= (commit ? '0 : ready_mask) | (merge ? rx_mask : '0);
        end
    end

`ifdef POV_SPI_READBACK_EN
    logic sclk_fall, rb_valid, rb_bit, miso_q;

    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign rb_valid  = in_payload && !ss_sync[1] && (idx < NUM_IDX);

    // Select the live word at idx, then the bit about to be overwritten, MSB first.
    always_comb begin
        rb_bit = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++)
            for (int j = 0; j < WORD_W; j++)
                if (idx == HDR_W'(i) && bit_cnt == CNT_W'(j))
                    rb_bit = o_words[(NUM_WORDS-1-i)*WORD_W + WORD_W - 1 - j];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       miso_q <= 1'b0;
        else if (!rb_valid) miso_q <= 1'b0;
        else if (sclk_fall) miso_q <= rb_bit;
    end

    assign spi.o_miso = miso_q;
`else
    assign spi.o_miso = 1'b0;
`endif
endmodule

// File: tb/tb_pov_spi_loader.sv
// Self-checking bench for pov_spi_loader: a frame-level model of rx/ready/live words compared every quiet cycle.
// Readback checks follow POV_SPI_READBACK_EN.
module tb_pov_spi_loader;
    localparam int WW = 24;
    localparam int NW = 6;

    logic clk, reset_n, load_if_ready;
    logic [NW*WW-1:0] o_words;
    logic o_pending, o_frame_err;

    pov_spi_loader_if spi_bus ();

    pov_spi_loader dut (
        .clk(clk), .reset_n(reset_n), .spi(spi_bus), .load_if_ready(load_if_ready),
        .o_words(o_words), .o_pending(o_pending), .o_frame_err(o_frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0, n_miss = 0;
    int err_pulses = 0, exp_err = 0;
    bit check_en = 0;
    logic [31:0] miso_cap = '0;
    logic [NW*WW-1:0] reset_img = {24'h001800, 24'h001800, 24'h000000, 24'h001000, 24'hFFF800, 24'h000000};

    // Frame-level model: live words, ready buffer + mask, and the last frame's rx result.
    logic [WW-1:0] m_live [NW], m_ready [NW], m_rx [NW];
    logic [NW-1:0] m_rmask, m_rxmask;
    logic [WW-1:0] fq [$];

    task automatic check(input string name, input logic [NW*WW-1:0] act, input logic [NW*WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NW*WW-1:0] pack_live();
        logic [NW*WW-1:0] p;
        for (int i = 0; i < NW; i++) p[(NW-1-i)*WW +: WW] = m_live[i];
        return p;
    endfunction

    task automatic model_init();
        for (int i = 0; i < NW; i++) begin
            m_live[i]  = reset_img[(NW-1-i)*WW +: WW];
            m_ready[i] = '0;
        end
        m_rmask = '0;
    endtask

    task automatic model_frame(input int hdr);
        int ix;
        m_rxmask = '0;
        ix = hdr;
        if (hdr >= NW) exp_err++;
        else
            foreach (fq[k]) if (ix < NW) begin
                m_rx[ix] = fq[k];
                m_rxmask[ix] = 1'b1;
                ix++;
            end
    endtask

    task automatic model_merge();
        for (int i = 0; i < NW; i++) if (m_rxmask[i]) m_ready[i] = m_rx[i];
        m_rmask |= m_rxmask;
    endtask

    task automatic model_commit();
        for (int i = 0; i < NW; i++) if (m_rmask[i]) m_live[i] = m_ready[i];
        m_rmask = '0;
    endtask

    always @(negedge clk) if (reset_n && o_frame_err) err_pulses++;

    always @(negedge clk) if (check_en) begin
        check("live_words", o_words, pack_live());
        check("pending", {{(NW*WW-1){1'b0}}, o_pending}, {{(NW*WW-1){1'b0}}, m_rmask != '0});
        check("frame_err_idle", {{(NW*WW-1){1'b0}}, o_frame_err}, '0);
    end

    task automatic spi_bit(input logic b);
        spi_bus.i_mosi = b;
        repeat (5) @(negedge clk);
        miso_cap = {miso_cap[30:0], spi_bus.o_miso};
        spi_bus.i_sclk = 1'b1;
        repeat (5) @(negedge clk);
        spi_bus.i_sclk = 1'b0;
    endtask

    task automatic spi_value(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    // One frame from fq; sync_load raises load_if_ready on exactly the edge that merges this frame.
    task automatic drive_frame(input logic [7:0] hdr, input int trail, input bit sync_load);
        spi_bus.i_ss_n = 1'b0;
        repeat (5) @(negedge clk);
        spi_value({24'h0, hdr}, 8);
        foreach (fq[k]) spi_value({8'h0, fq[k]}, WW);
        for (int t = 0; t < trail; t++) spi_bit(1'(t));
        repeat (5) @(negedge clk);
        check_en = 0;
        spi_bus.i_ss_n = 1'b1;
        if (sync_load) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            load_if_ready = 1'b1;
            @(posedge clk);
            #1 load_if_ready = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] hdr, input int trail);
        drive_frame(hdr, trail, 1'b0);
        model_frame(int'(hdr));
        model_merge();
        check_en = 1;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_if_ready = 1'b1;
        @(posedge clk);
        #1 load_if_ready = 1'b0;
        model_commit();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        load_if_ready = 1'b0;
        spi_bus.i_sclk = 1'b0;
        spi_bus.i_ss_n = 1'b1;
        spi_bus.i_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_words", o_words, 144'h001800_001800_000000_001000_FFF800_000000);
        check("reset_pending", {143'h0, o_pending}, '0);
        check("reset_frame_err", {143'h0, o_frame_err}, '0);
        check("reset_miso", {143'h0, spi_bus.o_miso}, '0);
        reset_n = 1'b1;
        model_init();
        repeat (5) @(negedge clk);
        check("reset_word3", {120'h0, o_words[71:48]}, {120'h0, 24'h001000});
        check_en = 1;

        // Readback: payload word 0 at header 1 returns live word 1.
        fq = {24'h00ABCD};
        frame(8'h01, 0);
`ifdef POV_SPI_READBACK_EN
        check("readback_word1", {112'h0, miso_cap}, {120'h0, 24'h001800});
`else
        check("miso_tied_low", {112'h0, miso_cap}, '0);
`endif
        pulse_load();

        // Full frame then commit.
        fq = {24'h001800, 24'h002000, 24'h000400, 24'h000C00, 24'hFFF000, 24'h000000};
        frame(8'h00, 0);
        check("full_pending", {143'h0, o_pending}, {143'h0, 1'b1});
        pulse_load();
        check("full_words", o_words, 144'h001800_002000_000400_000C00_FFF000_000000);
        check("full_pending_clear", {143'h0, o_pending}, '0);

        // Partial update of words 4 and 5.
        fq = {24'hFFF800, 24'h000400};
        frame(8'h04, 0);
        pulse_load();
        check("partial_words", o_words, 144'h001800_002000_000400_000C00_FFF800_000400);

        // Out-of-range header.
        fq = {24'h777777};
        frame(8'h06, 0);
        check("err_pulse_once", 144'(err_pulses), 144'd1);
        check("err_no_pending", {143'h0, o_pending}, '0);

        // Truncated trailing word: the 10 extra bits are dropped.
        fq = {24'h111111, 24'h222222};
        frame(8'h00, 10);
        pulse_load();
        check("trunc_words", o_words, 144'h111111_222222_000400_000C00_FFF800_000400);

        // Words past the last index are discarded without error.
        fq = {24'h0A0A0A, 24'h0B0B0B};
        frame(8'h05, 0);
        pulse_load();

        // Two merges before a commit: newer value wins.
        fq = {24'h123456};
        frame(8'h02, 0);
        fq = {24'h654321};
        frame(8'h02, 0);
        pulse_load();
        check("overwrite_word2", {120'h0, o_words[95:72]}, {120'h0, 24'h654321});

        // Header-only frame: nothing pending.
        fq.delete();
        frame(8'h03, 0);
        check("empty_no_pending", {143'h0, o_pending}, '0);

        // Collision: B merges on the same edge that commits A.
        fq = {24'hAAAAAA};
        frame(8'h00, 0);
        fq = {24'hBBBBBB};
        drive_frame(8'h01, 0, 1'b1);
        model_frame(1);
        model_commit();
        model_merge();
        check_en = 1;
        @(negedge clk);
        check("collide_word0", {120'h0, o_words[143:120]}, {120'h0, 24'hAAAAAA});
        check("collide_b_pending", {143'h0, o_pending}, {143'h0, 1'b1});
        pulse_load();
        check("collide_word1", {120'h0, o_words[119:96]}, {120'h0, 24'hBBBBBB});

        // Reset mid-frame with /SS held low: nothing captured until /SS toggles.
        spi_bus.i_ss_n = 1'b0;
        repeat (5) @(negedge clk);
        spi_value(32'h0, 13);
        check_en = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_init();
        repeat (5) @(negedge clk);
        check_en = 1;
        spi_value(32'h0, 8);
        spi_value(32'h00DEAD00, WW);
        repeat (5) @(negedge clk);
        spi_bus.i_ss_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midreset_no_pending", {143'h0, o_pending}, '0);
        fq = {24'hC0FFEE};
        frame(8'h00, 0);
        pulse_load();
        check("rearmed_word0", {120'h0, o_words[143:120]}, {120'h0, 24'hC0FFEE});

        check_en = 0;
        check("err_total", 144'(err_pulses), 144'(exp_err));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
